// File: rtl/prog_timer_pkg.sv
// Shared definitions for the programmable countdown timer: FSM state encoding
// and default register widths.
package prog_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH     = 26;
  localparam int DEFAULT_PSC_WIDTH = 8;

endpackage

// File: rtl/prog_timer_prescale_tick.sv
// Prescaler: emits one tick every (divisor+1) enabled cycles; holds while disabled.
module prescale_tick #(
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [PSC_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] pre_cnt_q;
  logic [PSC_WIDTH-1:0] pre_cnt_d;

  assign tick = enable && (pre_cnt_q == divisor);

  // clear outranks enable so a restart always begins a fresh prescale period
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (enable) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PSC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable countdown timer with prescaler, one-shot/auto-reload modes and
// pause/stop control. dbg_state exposes the FSM state for observation.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int PSC_WIDTH = DEFAULT_PSC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [PSC_WIDTH-1:0] prescale,
  input  logic                 mode_reload,
  output logic                 busy,
  output logic                 done_pulse,
  output logic                 done_level,
  output logic [WIDTH-1:0]     count,
  output logic [1:0]           dbg_state
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     load_q, load_d;
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic                 reload_q, reload_d;
  logic                 done_pulse_q, done_pulse_d;
  logic                 done_level_q, done_level_d;
  logic                 tick;

  prescale_tick #(.PSC_WIDTH(PSC_WIDTH)) u_prescale (
    .clk     (clk),
    .rst     (rst),
    .clear   (stop || start),
    .enable  ((state_q == ST_RUN) && !pause),
    .divisor (psc_q),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    load_d       = load_q;
    psc_d        = psc_q;
    reload_d     = reload_q;
    done_pulse_d = 1'b0;
    done_level_d = done_level_q;

    if (stop) begin
      state_d      = ST_IDLE;
      count_d      = '0;
      done_level_d = 1'b0;
    end else if (start) begin
      load_d   = load_val;
      psc_d    = prescale;
      reload_d = mode_reload;
      if (load_val == '0) begin
        // a zero period finishes immediately regardless of mode
        state_d      = ST_DONE;
        count_d      = '0;
        done_pulse_d = 1'b1;
        done_level_d = 1'b1;
      end else begin
        state_d      = ST_RUN;
        count_d      = load_val;
        done_level_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
              done_pulse_d = 1'b1;
              if (reload_q) begin
                count_d = load_q;
              end else begin
                count_d      = '0;
                state_d      = ST_DONE;
                done_level_d = 1'b1;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      load_q       <= '0;
      psc_q        <= '0;
      reload_q     <= 1'b0;
      done_pulse_q <= 1'b0;
      done_level_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      load_q       <= load_d;
      psc_q        <= psc_d;
      reload_q     <= reload_d;
      done_pulse_q <= done_pulse_d;
      done_level_q <= done_level_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done_pulse = done_pulse_q;
  assign done_level = done_level_q;
  assign count      = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer: directed scenarios then random control traffic, all
// checked every cycle against an elapsed-time model of the timer.
module tb_prog_timer;

  localparam int W  = 26;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop, pause, mode_reload;
  logic [W-1:0]  load_val;
  logic [PW-1:0] prescale;
  logic          busy, done_pulse, done_level;
  logic [W-1:0]  count;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  int npulse   = 0;

  // model: elapsed effective cycles within the current period
  bit     m_active, m_paused, m_level, m_pulse, m_reload;
  longint m_l, m_p, m_e;
  logic [W-1:0] exp_q[$];

  prog_timer #(.WIDTH(W), .PSC_WIDTH(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .load_val    (load_val),
    .prescale    (prescale),
    .mode_reload (mode_reload),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .done_level  (done_level),
    .count       (count),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, s, t, p, input longint lv, ps, input bit md);
    m_pulse = 1'b0;
    if (r) begin
      m_active = 0; m_paused = 0; m_level = 0; m_e = 0;
      m_l = 0; m_p = 0; m_reload = 0;
    end else if (t) begin
      m_active = 0; m_paused = 0; m_level = 0; m_e = 0;
    end else if (s) begin
      m_l = lv; m_p = ps; m_reload = md; m_e = 0; m_paused = 0;
      if (lv == 0) begin
        m_active = 0; m_level = 1; m_pulse = 1;
      end else begin
        m_active = 1; m_level = 0;
      end
    end else if (m_active) begin
      if (m_paused) begin
        if (!p) m_paused = 0;
      end else if (p) begin
        m_paused = 1;
      end else begin
        m_e++;
        if (m_e == m_l * (m_p + 1)) begin
          m_pulse = 1;
          m_e = 0;
          if (!m_reload) begin
            m_active = 0; m_level = 1;
          end
        end
      end
    end
    exp_q.push_back(m_active ? W'(m_l - m_e / (m_p + 1)) : W'(0));
  endtask

  task automatic step(input bit r, s, t, p, input logic [W-1:0] lv,
                      input logic [PW-1:0] ps, input bit md);
    logic [W-1:0] exp_cnt;
    logic [1:0]   exp_st;
    rst = r; start = s; stop = t; pause = p;
    load_val = lv; prescale = ps; mode_reload = md;
    @(posedge clk);
    model_edge(r, s, t, p, longint'(lv), longint'(ps), md);
    #1;
    exp_cnt = exp_q.pop_front();
    exp_st  = m_active ? (m_paused ? 2'd2 : 2'd1) : (m_level ? 2'd3 : 2'd0);
    if (done_pulse === 1'b1) npulse++;
    check("count", 64'(count), 64'(exp_cnt));
    check("done_pulse", 64'(done_pulse), 64'(m_pulse));
    check("done_level", 64'(done_level), 64'(m_level));
    check("busy", 64'(busy), 64'(m_active));
    check("state", 64'(dbg_state), 64'(exp_st));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic pause_for(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, '0, '0, 0);
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0, '0, '0, 0);
    step(1, 0, 0, 0, '0, '0, 0);
    check("reset_count", 64'(count), 64'd0);

    // one-shot L=5 P=0: pulse after the fifth edge following start
    npulse = 0;
    step(0, 1, 0, 0, W'(5), PW'(0), 0);
    idle(4);
    check("os_pre_pulse", 64'(npulse), 64'd0);
    idle(1);
    check("os_pulse_time", 64'(done_pulse), 64'd1);
    idle(6);
    check("os_pulses", 64'(npulse), 64'd1);
    check("os_level_held", 64'(done_level), 64'd1);

    // reset held 3 cycles mid-run
    step(0, 1, 0, 0, W'(20), PW'(1), 0);
    idle(4);
    step(1, 0, 0, 0, '0, '0, 0);
    step(1, 0, 0, 0, '0, '0, 0);
    step(1, 0, 0, 0, '0, '0, 0);
    check("rst_state_idle", 64'(dbg_state), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    idle(2);

    // reload L=3 P=2: pulse every 9 cycles
    npulse = 0;
    step(0, 1, 0, 0, W'(3), PW'(2), 1);
    idle(36);
    check("reload_pulses", 64'(npulse), 64'd4);
    check("reload_count", 64'(count), 64'd3);
    step(0, 0, 1, 0, '0, '0, 0);

    // one-shot L=4 P=1 with 6-cycle pause at count=2
    npulse = 0;
    step(0, 1, 0, 0, W'(4), PW'(1), 0);
    idle(4);
    check("pause_at_two", 64'(count), 64'd2);
    pause_for(6);
    check("pause_hold", 64'(count), 64'd2);
    idle(10);
    check("pause_pulses", 64'(npulse), 64'd1);

    // start+stop together while running, then zero-period start
    npulse = 0;
    step(0, 1, 0, 0, W'(10), PW'(0), 0);
    idle(3);
    step(0, 1, 1, 0, W'(4), PW'(0), 0);
    check("stop_wins_state", 64'(dbg_state), 64'd0);
    idle(6);
    check("stop_no_pulse", 64'(npulse), 64'd0);
    step(0, 1, 0, 0, W'(0), PW'(3), 1);
    check("zero_load_pulse", 64'(done_pulse), 64'd1);
    idle(2);
    check("zero_load_pulses", 64'(npulse), 64'd1);

    // restart at count=2 with a longer period
    npulse = 0;
    step(0, 1, 0, 0, W'(5), PW'(0), 0);
    idle(3);
    step(0, 1, 0, 0, W'(7), PW'(0), 0);
    check("restart_count", 64'(count), 64'd7);
    idle(6);
    check("restart_no_pulse", 64'(npulse), 64'd0);
    idle(3);

    // random control traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 5) == 0),
           W'($urandom_range(0, 6)),
           PW'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
